// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the bus-mapped UART transmitter:
//   - tx_state_e : serialiser FSM states
//   - REG_*      : register offsets, selected by busAddr[3:2]
//   - STAT_*     : bit positions inside the STATUS register
//   - CTRL_*     : bit positions inside the CTRL register
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head read, so a pop can load the
//   head entry into the serialiser on the same edge that retires it.
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset (empties the FIFO)
//   push   in   write wData this edge (dropped when full unless popping too)
//   pop    in   retire the head entry this edge (ignored when empty)
//   wData  in   WIDTH-bit entry to store
//   rData  out  head entry
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
//   count  out  number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wData,
  output logic [WIDTH-1:0]         rData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtrReg;
  logic [AW-1:0]    rdPtrReg;
  logic [AW:0]      countReg;
  logic             doPush;
  logic             doPop;

  assign full  = (countReg == (AW+1)'(DEPTH));
  assign empty = (countReg == '0);
  assign count = countReg;
  assign rData = mem[rdPtrReg];

  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrReg] <= wData;
    end
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      if (doPop) begin
        rdPtrReg <= rdPtrReg + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx
//   Memory-mapped 8N1 UART transmitter on the CPU data bus. The CPU stores
//   bytes to TXDATA; they queue in a FIFO and a baud-timed FSM shifts them
//   out LSB first on tx. Registers sit in a 4 KB window at BASE_ADDR,
//   decoded on busAddr[3:2]:
//     0x0 TXDATA  W: push byte         R: 0
//     0x4 STATUS  R: busy/full/empty/ovf/count   W: bit3=1 clears ovf
//     0x8 CTRL    RW: [0] en, [1] irq_en
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   busWe     in   bus write strobe
//   busAddr   in   bus byte address
//   busWData  in   bus write data
//   busRData  out  register read data (combinational, 0 when not selected)
//   sel       out  address falls in this block's window
//   tx        out  serial line, idle high
//   irq       out  level interrupt: FIFO drained and line idle (registered)
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter int          CLK_HZ     = 100_000_000,
  parameter int          BAUD       = 9600,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busWe,
  input  logic [31:0] busAddr,
  input  logic [31:0] busWData,
  output logic [31:0] busRData,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- bus decode ----------------
  logic [1:0] regOff;
  logic       wrEn;
  logic       pushReq;
  logic       ovfClr;
  logic       ctrlWr;
  logic       unusedBits;

  assign sel     = (busAddr[31:12] == BASE_ADDR[31:12]);
  assign regOff  = busAddr[3:2];
  assign wrEn    = busWe && sel;
  assign pushReq = wrEn && (regOff == REG_TXDATA);
  assign ovfClr  = wrEn && (regOff == REG_STATUS) && busWData[STAT_OVF];
  assign ctrlWr  = wrEn && (regOff == REG_CTRL);

  // Address bits inside the window beyond the register index, and the upper
  // write-data bits, carry no meaning for this block.
  assign unusedBits = ^{busAddr[11:4], busAddr[1:0], busWData[31:8]};

  // ---------------- FIFO ----------------
  logic            popReq;
  logic [7:0]      fifoRData;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [CNTW-1:0] fifoCount;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) txFifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (popReq),
    .wData (busWData[7:0]),
    .rData (fifoRData),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  // ---------------- control / status registers ----------------
  logic enReg;
  logic irqEnReg;
  logic ovfReg;
  logic irqReg;
  logic busy;

  tx_state_e stateReg, stateNext;
  logic [CW-1:0] baudReg, baudNext;
  logic [2:0]    bitReg, bitNext;
  logic [7:0]    shiftReg, shiftNext;
  logic          txReg, txNext;
  logic          baudDone;

  assign busy = (stateReg != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enReg    <= 1'b0;
      irqEnReg <= 1'b0;
      ovfReg   <= 1'b0;
      irqReg   <= 1'b0;
    end else begin
      if (ctrlWr) begin
        enReg    <= busWData[CTRL_EN];
        irqEnReg <= busWData[CTRL_IRQ_EN];
      end
      // A byte is lost only when full and the FSM is not popping this edge.
      if (pushReq && fifoFull && !popReq) begin
        ovfReg <= 1'b1;
      end else if (ovfClr) begin
        ovfReg <= 1'b0;
      end
      irqReg <= irqEnReg && fifoEmpty && !busy;
    end
  end

  always_comb begin
    busRData = '0;
    if (sel) begin
      case (regOff)
        REG_STATUS: begin
          busRData[STAT_BUSY]                 = busy;
          busRData[STAT_FULL]                 = fifoFull;
          busRData[STAT_EMPTY]                = fifoEmpty;
          busRData[STAT_OVF]                  = ovfReg;
          busRData[STAT_COUNT_LSB +: CNTW]    = fifoCount;
        end
        REG_CTRL: begin
          busRData[CTRL_EN]     = enReg;
          busRData[CTRL_IRQ_EN] = irqEnReg;
        end
        default: busRData = '0;
      endcase
    end
  end

  // ---------------- serialiser FSM ----------------
  // Every state entry restarts the baud counter, so each bit is exactly DIV
  // clocks and a back-to-back frame starts on the edge the stop bit ends.
  assign baudDone = (baudReg == CW'(DIV - 1));

  always_comb begin
    stateNext = stateReg;
    baudNext  = baudReg + 1'b1;
    bitNext   = bitReg;
    shiftNext = shiftReg;
    popReq    = 1'b0;
    case (stateReg)
      IDLE: begin
        baudNext = '0;
        if (enReg && !fifoEmpty) begin
          popReq    = 1'b1;
          shiftNext = fifoRData;
          stateNext = START;
        end
      end
      START: begin
        if (baudDone) begin
          baudNext  = '0;
          bitNext   = '0;
          stateNext = DATA;
        end
      end
      DATA: begin
        if (baudDone) begin
          baudNext  = '0;
          shiftNext = shiftReg >> 1;
          if (bitReg == 3'd7) begin
            stateNext = STOP;
          end else begin
            bitNext = bitReg + 1'b1;
          end
        end
      end
      STOP: begin
        if (baudDone) begin
          baudNext = '0;
          if (enReg && !fifoEmpty) begin
            popReq    = 1'b1;
            shiftNext = fifoRData;
            stateNext = START;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: begin
        baudNext  = '0;
        stateNext = IDLE;
      end
    endcase

    // tx is registered from the next state so the line is glitch-free and
    // changes on the same edge as the state.
    case (stateNext)
      START:   txNext = 1'b0;
      DATA:    txNext = shiftNext[0];
      default: txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      baudReg  <= '0;
      bitReg   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      stateReg <= stateNext;
      baudReg  <= baudNext;
      bitReg   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  assign tx  = txReg;
  assign irq = irqReg;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

  localparam int          CLK_HZ = 1000;
  localparam int          BAUD   = 100;
  localparam int          DIV    = 10;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_CTRL   = BASE + 32'h8;

  logic        clk;
  logic        reset;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        sel;
  logic        tx;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bytes the FIFO should hold, in line order, plus sticky ovf.
  logic [7:0] expQ[$];
  logic       modelOvf;

  bus_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .sel      (sel),
    .tx       (tx),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end else begin
      $display("ok   %s: 0x%0h", tag, observed);
    end
  endtask

  function automatic logic [31:0] statusWord(input int b, input int f, input int e, input int o, input int c);
    return 32'(b + 2 * f + 4 * e + 8 * o + 16 * c);
  endfunction

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    busAddr  = addr;
    busWData = data;
    busWe    = 1'b1;
    @(posedge clk);
    #1;
    busWe = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    busWe   = 1'b0;
    busAddr = addr;
    #1;
    data = busRData;
  endtask

  task automatic pushByte(input logic [7:0] b);
    busWrite(A_TXDATA, {24'h0, b});
    if (expQ.size() < DEPTH) expQ.push_back(b);
    else modelOvf = 1'b1;
  endtask

  // Checks one 8N1 frame sample-by-sample on falling edges. If dropBit >= 0,
  // CTRL is written to 0 across the first clock of that bit position.
  task automatic checkFrame(input int dropBit);
    logic [7:0] b;
    logic       expBit;
    int         bad;
    if (expQ.size() == 0) begin
      checkVal("frame_model_empty", 32'd1, 32'd0);
      return;
    end
    b = expQ.pop_front();
    for (int bitIdx = 0; bitIdx < 10; bitIdx++) begin
      if (bitIdx == 0)      expBit = 1'b0;
      else if (bitIdx == 9) expBit = 1'b1;
      else                  expBit = b[bitIdx - 1];
      bad = 0;
      for (int k = 0; k < DIV; k++) begin
        @(negedge clk);
        if (tx !== expBit) bad++;
        if (bitIdx == dropBit && k == 0) begin
          busAddr  = A_CTRL;
          busWData = 32'h0;
          busWe    = 1'b1;
        end
        if (bitIdx == dropBit && k == 1) busWe = 1'b0;
      end
      checkVal($sformatf("byte%02h_bit%0d_badsamples", b, bitIdx), 32'(bad), 32'd0);
    end
  endtask

  task automatic checkIdle(input int cycles, input string tag);
    int bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checkVal(tag, 32'(bad), 32'd0);
  endtask

  task automatic checkEnd(input logic expIrq);
    logic [31:0] d;
    @(negedge clk);
    busRead(A_STATUS, d);
    checkVal("status_after_frames", d, statusWord(0, 0, 1, int'(modelOvf), 0));
    checkVal("irq_lag", 32'(irq), 32'd0);
    @(negedge clk);
    checkVal("irq_after_drain", 32'(irq), 32'(expIrq));
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    logic        irqEn;

    reset    = 1'b0;
    busWe    = 1'b0;
    busAddr  = 32'h0;
    busWData = 32'h0;
    modelOvf = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkVal("reset_tx", 32'(tx), 32'd1);
    checkVal("reset_irq", 32'(irq), 32'd0);
    busRead(A_STATUS, d);
    checkVal("reset_status", d, 32'h004);
    busRead(A_CTRL, d);
    checkVal("reset_ctrl", d, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Decode
    busRead(32'h2000_0004, d);
    checkVal("sel_outside", 32'(sel), 32'd0);
    checkVal("rdata_outside", d, 32'h0);
    busRead(BASE + 32'hFFC, d);
    checkVal("sel_inside", 32'(sel), 32'd1);
    checkVal("rdata_offset3", d, 32'h0);
    busRead(A_TXDATA, d);
    checkVal("rdata_txdata", d, 32'h0);

    // Single byte with en and irq_en already set
    busWrite(A_CTRL, 32'h3);
    busRead(A_CTRL, d);
    checkVal("ctrl_readback", d, 32'h3);
    pushByte(8'h55);
    @(negedge clk);
    checkVal("pre_start_tx", 32'(tx), 32'd1);
    checkFrame(-1);
    checkEnd(1'b1);

    // Overflow: 17 bytes with en=0
    busWrite(A_CTRL, 32'h0);
    for (int i = 0; i < 17; i++) pushByte(8'($urandom));
    busRead(A_STATUS, d);
    checkVal("ovf_status", d, statusWord(0, 1, 0, int'(modelOvf), 16));
    busWrite(A_STATUS, 32'h8);
    modelOvf = 1'b0;
    busRead(A_STATUS, d);
    checkVal("ovf_cleared", d, statusWord(0, 1, 0, 0, 16));
    busWrite(A_CTRL, 32'h1);
    @(negedge clk);
    checkVal("pre_start_drain", 32'(tx), 32'd1);
    for (int i = 0; i < DEPTH; i++) checkFrame(-1);
    checkEnd(1'b0);

    // Back-to-back writes with en=1: frames must abut
    pushByte(8'hA3);
    pushByte(8'h0F);
    checkFrame(-1);
    checkFrame(-1);
    checkEnd(1'b0);

    // Clear en during DATA of the first of two bytes
    busWrite(A_CTRL, 32'h0);
    pushByte(8'($urandom));
    pushByte(8'($urandom));
    busWrite(A_CTRL, 32'h1);
    @(negedge clk);
    checkVal("pre_start_drop", 32'(tx), 32'd1);
    checkFrame(4);
    checkIdle(3 * DIV, "idle_after_en_clear");
    busRead(A_STATUS, d);
    checkVal("status_after_en_clear", d, statusWord(0, 0, 0, 0, 1));
    busWrite(A_CTRL, 32'h1);
    @(negedge clk);
    checkVal("pre_start_resume", 32'(tx), 32'd1);
    checkFrame(-1);
    checkEnd(1'b0);

    // Randomized bursts
    for (int iter = 0; iter < 3; iter++) begin
      busWrite(A_CTRL, 32'h0);
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) pushByte(8'($urandom));
      busRead(A_STATUS, d);
      checkVal($sformatf("rand%0d_status", iter), d,
               statusWord(0, (n == DEPTH) ? 1 : 0, 0, 0, n));
      irqEn = 1'($urandom_range(0, 1));
      busWrite(A_CTRL, {30'h0, irqEn, 1'b1});
      @(negedge clk);
      checkVal($sformatf("rand%0d_pre_start", iter), 32'(tx), 32'd1);
      for (int i = 0; i < n; i++) checkFrame(-1);
      checkEnd(irqEn);
    end

    // Asynchronous reset during DATA of an all-zero byte (tx is low there)
    busWrite(A_CTRL, 32'h1);
    pushByte(8'h00);
    repeat (3 * DIV) @(negedge clk);
    checkVal("mid_frame_tx_low", 32'(tx), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    checkVal("async_reset_tx", 32'(tx), 32'd1);
    checkVal("async_reset_irq", 32'(irq), 32'd0);
    busRead(A_STATUS, d);
    checkVal("async_reset_status", d, 32'h004);
    busRead(A_CTRL, d);
    checkVal("async_reset_ctrl", d, 32'h0);
    expQ.delete();
    modelOvf = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    busWrite(A_CTRL, 32'h1);
    checkIdle(3 * DIV, "no_residual_frame");
    busRead(A_STATUS, d);
    checkVal("status_after_reset", d, 32'h004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
